// File: rtl/disp_sched.sv
// disp_sched: picks which requester (measurement, keypad, alarm) owns
// the display value and key nibble, with timed keypad and alarm holds.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   meas_val/meas_key live measurement and its nibble (background)
//   kp_req/kp_val/kp_key keypad request (level, held until kp_ack)
//   alm_req/alm_code  alarm request (level) and code
//   num/key           registered value and nibble to the display driver
//   src               owner: 0 meas, 1 keypad, 2 alarm
//   blank             blank all digits (alarm blink)
//   kp_ack/alm_ack    one-cycle accept pulses
// Build option: DISP_SCHED_BLINK_EN adds alarm blinking on blank.
module disp_sched #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_MS    = 2000,
  parameter int ALM_MIN_MS = 1000,
  parameter int BLINK_MS   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] meas_val,
  input  logic [3:0]  meas_key,
  input  logic        kp_req,
  input  logic [11:0] kp_val,
  input  logic [3:0]  kp_key,
  input  logic        alm_req,
  input  logic [11:0] alm_code,
  output logic [11:0] num,
  output logic [3:0]  key,
  output logic [1:0]  src,
  output logic        blank,
  output logic        kp_ack,
  output logic        alm_ack
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HMAX = (HOLD_MS > ALM_MIN_MS) ? HOLD_MS : ALM_MIN_MS;
  localparam int HW = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYPAD = 2'd1,
    ALARM  = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_dec;
  logic          hold_done;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // The hold ends on the very tick that takes it to zero, so the
  // on-screen time is HOLD_MS-1..HOLD_MS ms regardless of tick phase.
  assign hold_done = (hold == '0) || (tick && hold == HW'(1));
  assign hold_dec  = (tick && hold != '0) ? hold - 1'b1 : hold;

  assign src = state;

`ifdef DISP_SCHED_BLINK_EN
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS + 1) : 1;
  logic [BW-1:0] bcnt;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      num     <= '0;
      key     <= '0;
      kp_ack  <= 1'b0;
      alm_ack <= 1'b0;
`ifdef DISP_SCHED_BLINK_EN
      bcnt    <= '0;
      blank   <= 1'b0;
`endif
    end else begin
      kp_ack  <= 1'b0;
      alm_ack <= 1'b0;
      hold    <= hold_dec;
`ifdef DISP_SCHED_BLINK_EN
      blank   <= 1'b0;
      bcnt    <= BW'(BLINK_MS);
`endif
      unique case (state)
        IDLE: begin
          if (alm_req) begin
            state   <= ALARM;
            num     <= alm_code;
            key     <= 4'hA;
            alm_ack <= 1'b1;
            hold    <= HW'(ALM_MIN_MS);
          end else if (kp_req) begin
            state  <= KEYPAD;
            num    <= kp_val;
            key    <= kp_key;
            kp_ack <= 1'b1;
            hold   <= HW'(HOLD_MS);
          end else begin
            num <= meas_val;
            key <= meas_key;
          end
        end
        KEYPAD: begin
          if (alm_req) begin
            state   <= ALARM;
            num     <= alm_code;
            key     <= 4'hA;
            alm_ack <= 1'b1;
            hold    <= HW'(ALM_MIN_MS);
          end else if (kp_req && !kp_ack) begin
            // kp_ack high means the requester has not yet seen the
            // previous accept, so its level is not a new request.
            num    <= kp_val;
            key    <= kp_key;
            kp_ack <= 1'b1;
            hold   <= HW'(HOLD_MS);
          end else if (hold_done) begin
            state <= IDLE;
            num   <= meas_val;
            key   <= meas_key;
          end
        end
        ALARM: begin
          if (!alm_req && hold_done) begin
            if (kp_req) begin
              state  <= KEYPAD;
              num    <= kp_val;
              key    <= kp_key;
              kp_ack <= 1'b1;
              hold   <= HW'(HOLD_MS);
            end else begin
              state <= IDLE;
              num   <= meas_val;
              key   <= meas_key;
            end
          end else begin
`ifdef DISP_SCHED_BLINK_EN
            blank <= blank;
            bcnt  <= bcnt;
            if (tick) begin
              if (bcnt <= BW'(1)) begin
                blank <= ~blank;
                bcnt  <= BW'(BLINK_MS);
              end else begin
                bcnt <= bcnt - 1'b1;
              end
            end
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler that decides which source owns the 4-digit BCD value and the key nibble sent to the multiplexed seven-segment driver. Three requesters share the display: the live measurement (background), keypad entry (timed hold), and alarm code (highest priority, optionally blinking). It sits between the measurement, keypad and alarm logic and the display driver's `num`/`key` inputs.

## Interface
- `TICK_DIV`, 50000: clocks per 1 ms tick (50 MHz → 1 kHz).
- `HOLD_MS`, 2000: ms a keypad value stays on screen after its last accept.
- `ALM_MIN_MS`, 1000: minimum ms an alarm stays on screen after entry.
- `BLINK_MS`, 250: alarm blink half-period in ms (only with `DISP_SCHED_BLINK_EN`).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `meas_val`  in  12  live measurement, 3 BCD digits.
- `meas_key`  in  4  nibble shown with the measurement.
- `kp_req`  in  1  keypad request, level. Held until `kp_ack`.
- `kp_val`  in  12  keypad BCD value.
- `kp_key`  in  4  last key pressed.
- `alm_req`  in  1  alarm active, level.
- `alm_code`  in  12  alarm code, BCD.
- `num`  out  12  value to the display driver.
- `key`  out  4  nibble to the display driver.
- `src`  out  2  current owner: 0 = meas, 1 = keypad, 2 = alarm.
- `blank`  out  1  1 = the display driver must blank all digits.
- `kp_ack`  out  1  one-cycle pulse when a keypad request is accepted.
- `alm_ack`  out  1  one-cycle pulse on alarm entry.

## Operation
- Free-running tick counter: 0..`TICK_DIV`-1. `tick` is high for one clock at wrap.
- Hold counter and blink counter advance only on `tick`.
- States: IDLE, KEYPAD, ALARM. Reset state is IDLE.
- **IDLE:** `num`/`key` follow `meas_val`/`meas_key`, registered every clock. `src`=0.
  - `alm_req`=1 → ALARM. This wins over `kp_req` in the same cycle.
  - Otherwise `kp_req`=1 → KEYPAD.
- **KEYPAD entry or re-accept:** latch `kp_val`/`kp_key`, pulse `kp_ack`, load the hold counter with `HOLD_MS`. `src`=1.
  - In KEYPAD, `kp_req`=1 with `kp_ack`=0 in the previous cycle re-accepts: new data is latched and the hold restarts.
  - Hold reaches 0 → IDLE.
  - `alm_req`=1 → ALARM. The keypad hold is discarded.
- **ALARM entry:** latch `alm_code` into `num`, force `key`=4'hA, pulse `alm_ack`, load the hold counter with `ALM_MIN_MS`. `src`=2.
  - `alm_code` is not re-latched while in ALARM.
  - `kp_req` is never acked in ALARM. The requester keeps holding it.
  - Exit only when `alm_req`=0 and the hold has reached 0.
  - On exit: go to KEYPAD (accept) if `kp_req`=1, else IDLE.
- `alm_req` re-asserting during ALARM has no effect: no new ack, no hold reload.

## Timing
- Every output is registered.
- Reset values: `num`=0, `key`=0, `src`=0, `blank`=0, `kp_ack`=0, `alm_ack`=0.
- Reset also clears all counters.
- Asynchronous reset mid-hold aborts the hold and returns to IDLE immediately.
- Request sampled at edge N → state, data and ack all update at edge N+1 (1-cycle latency).
- An ack is never high in two consecutive cycles.
- Hold duration is measured in ticks after entry: between `HOLD_MS`-1 and `HOLD_MS` full ms, since the first tick phase is arbitrary.
- The hold counter is wide enough for `HOLD_MS` and `ALM_MIN_MS`.
- A hold value of 0 means exit on the next clock.
- In IDLE, a measurement change appears on `num` one clock later.

## Configuration
- `DISP_SCHED_BLINK_EN` defined:
  - In ALARM, `blank` toggles every `BLINK_MS` ticks, starting at 0 on entry.
  - `blank` is forced to 0 in the same cycle ALARM is left.
- `DISP_SCHED_BLINK_EN` undefined:
  - `blank` is a constant 0.
  - The blink counter is not built.

## Test plan
Bench parameters: `TICK_DIV`=4, `HOLD_MS`=3, `ALM_MIN_MS`=2, `BLINK_MS`=1.

- **Reset:** `rst` high mid-KEYPAD → all outputs go to their reset values asynchronously. After release, `meas_val`=12'h123 appears on `num` 1 clock later with `src`=0.
- **Keypad hold:** `kp_req` with `kp_val`=12'h456 → `kp_ack` for 1 cycle, `num`=12'h456, `src`=1. Return to `src`=0 after 8–12 clocks.
- **Keypad re-accept:** second `kp_req` (12'h789) during the hold → second `kp_ack`, `num`=12'h789, hold restarted.
- **Priority:** simultaneous `kp_req` and `alm_req`, `alm_code`=12'h911 → `alm_ack` only, `num`=12'h911, `key`=4'hA, `src`=2.
- **Alarm minimum hold:** `alm_req` drops 1 clock after entry → ALARM is held ≥ 4 clocks. If `kp_req` is still high, exit goes to KEYPAD with `kp_ack`.
- **Blink:** with `DISP_SCHED_BLINK_EN`, `blank` toggles every 4 clocks in ALARM and is 0 after exit. Without the macro, `blank` stays 0 throughout.
